// File: rtl/sevenseg_pkg.sv
// Shared definitions for seven-segment display drivers: active-low segment
// encoding and the blank/anode-off levels.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Anode level that switches a digit off; replicate it across the digit count.
  localparam logic       ANODE_OFF = 1'b1;

  function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational hex nibble to active-low segment pattern, {dp,g,f,e,d,c,b,a}
// with the dp bit inactive.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = seg_decode(nibble);
  end

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed common-anode seven-segment driver with shadow/display
// double buffering, leading-zero suppression and PWM brightness.
module sevenseg_mux
  import sevenseg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DWELL_LOG2 = 17,
  parameter int PWM_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     anodes,
  output logic [7:0]            segments_out,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int                    IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DWELL_LOG2-1:0] DWELL_MAX  = {DWELL_LOG2{1'b1}};
  localparam logic [DWELL_LOG2-1:0] DWELL_ZERO = {DWELL_LOG2{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]     ANODES_OFF = {DIGITS{ANODE_OFF}};

  logic [DWELL_LOG2-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   sh_digits_q, sh_digits_d, dsp_digits_q, dsp_digits_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
  logic [DIGITS-1:0]     sh_blank_q, sh_blank_d, dsp_blank_q, dsp_blank_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  logic                  pending_q, pending_d;
  logic                  frame_start_q, frame_start_d;
  logic [DIGITS-1:0]     anodes_q, anodes_d;
  logic [7:0]            seg_q, seg_d;

  logic                  dwell_max_s, boundary_s, lit_s;
  logic [DIGITS-1:0]     supp_s;
  logic [3:0]            cur_nib_s;
  logic [7:0]            dec_seg_s;
  logic [PWM_BITS-1:0]   phase_s;

  sevenseg_decode u_decode (
    .nibble (cur_nib_s),
    .seg    (dec_seg_s)
  );

  // Leading-zero suppression over the display register, scanning from the top digit.
  always_comb begin
    logic higher_dark_v;
    supp_s        = {DIGITS{1'b0}};
    higher_dark_v = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (lz_en && (i != 0) && (dsp_digits_q[4*i +: 4] == 4'h0) && !dsp_dp_q[i] && higher_dark_v) begin
        supp_s[i] = 1'b1;
      end else begin
        supp_s[i] = 1'b0;
      end
      higher_dark_v = higher_dark_v & (supp_s[i] | dsp_blank_q[i]);
    end
  end

  always_comb begin
    cur_nib_s = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      cur_nib_s = cur_nib_s | ((idx_q == IDX_W'(i)) ? dsp_digits_q[4*i +: 4] : 4'h0);
    end
  end

  // Next-state for counters, shadow/display handshake, brightness and outputs.
  always_comb begin
    dwell_max_s   = (dwell_cnt_q == DWELL_MAX);
    boundary_s    = dwell_max_s && (idx_q == IDX_LAST);
    dwell_cnt_d   = dwell_cnt_q + DWELL_LOG2'(1);
    frame_start_d = boundary_s;

    if (dwell_max_s) begin
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    // The display takes the pre-load shadow even when a load lands on the boundary.
    if (boundary_s && pending_q) begin
      dsp_digits_d = sh_digits_q;
      dsp_dp_d     = sh_dp_q;
      dsp_blank_d  = sh_blank_q;
    end else begin
      dsp_digits_d = dsp_digits_q;
      dsp_dp_d     = dsp_dp_q;
      dsp_blank_d  = dsp_blank_q;
    end

    if (load) begin
      sh_digits_d = digits;
      sh_dp_d     = dp;
      sh_blank_d  = blank;
      pending_d   = 1'b1;
    end else begin
      sh_digits_d = sh_digits_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      pending_d   = (boundary_s && pending_q) ? 1'b0 : pending_q;
    end

    if (dwell_cnt_q == DWELL_ZERO) begin
      bright_d = brightness;
    end else begin
      bright_d = bright_q;
    end

    phase_s = dwell_cnt_q[DWELL_LOG2-1 -: PWM_BITS];
    lit_s   = !dsp_blank_q[idx_q] && !supp_s[idx_q] && (phase_s <= bright_q);

    if (lit_s) begin
      anodes_d = ~(DIGITS'(1) << idx_q);
      seg_d    = {~dsp_dp_q[idx_q], dec_seg_s[6:0]};
    end else begin
      anodes_d = ANODES_OFF;
      seg_d    = SEG_BLANK;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt_q   <= DWELL_ZERO;
      idx_q         <= {IDX_W{1'b0}};
      sh_digits_q   <= {(4*DIGITS){1'b0}};
      sh_dp_q       <= {DIGITS{1'b0}};
      sh_blank_q    <= {DIGITS{1'b0}};
      dsp_digits_q  <= {(4*DIGITS){1'b0}};
      dsp_dp_q      <= {DIGITS{1'b0}};
      dsp_blank_q   <= {DIGITS{1'b0}};
      bright_q      <= {PWM_BITS{1'b0}};
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      anodes_q      <= ANODES_OFF;
      seg_q         <= SEG_BLANK;
    end else begin
      dwell_cnt_q   <= dwell_cnt_d;
      idx_q         <= idx_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_blank_q    <= sh_blank_d;
      dsp_digits_q  <= dsp_digits_d;
      dsp_dp_q      <= dsp_dp_d;
      dsp_blank_q   <= dsp_blank_d;
      bright_q      <= bright_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      anodes_q      <= anodes_d;
      seg_q         <= seg_d;
    end
  end

  assign anodes       = anodes_q;
  assign segments_out = seg_q;
  assign frame_start  = frame_start_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Scoreboard bench for sevenseg_mux: a cycle-indexed reference model predicts
// each registered output word; a monitor compares the DUT against it.
module tb_sevenseg_mux;

  localparam int DIGITS     = 4;
  localparam int DWELL_LOG2 = 4;
  localparam int PWM_BITS   = 2;
  localparam int DWELL      = 16;
  localparam int FRAME      = 64;

  logic        clk;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic        load;
  logic [1:0]  brightness;
  logic [3:0]  anodes;
  logic [7:0]  segments_out;
  logic        frame_start;
  logic        pending;

  int total;
  int bad;
  int m;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    logic       pend;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] seg_tab [16];

  logic [3:0] mdl_sh_dig [4];
  logic [3:0] mdl_ds_dig [4];
  logic [3:0] mdl_sh_dp, mdl_sh_bl, mdl_ds_dp, mdl_ds_bl;
  int         mdl_br;
  logic       mdl_pend;

  sevenseg_mux #(
    .DIGITS     (DIGITS),
    .DWELL_LOG2 (DWELL_LOG2),
    .PWM_BITS   (PWM_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digits       (digits),
    .dp           (dp),
    .blank        (blank),
    .lz_en        (lz_en),
    .load         (load),
    .brightness   (brightness),
    .anodes       (anodes),
    .segments_out (segments_out),
    .frame_start  (frame_start),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, m);
    end
  endtask

  // Reference model: time since reset decides digit and dwell position.
  initial begin
    exp_t e;
    int   dwell, dig, phase;
    bit   bnd, all_dark, lit;
    bit   supp [4];
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    m = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m = 0;
        for (int i = 0; i < 4; i++) begin
          mdl_sh_dig[i] = 4'h0;
          mdl_ds_dig[i] = 4'h0;
        end
        mdl_sh_dp = 4'h0; mdl_sh_bl = 4'h0; mdl_ds_dp = 4'h0; mdl_ds_bl = 4'h0;
        mdl_br = 0; mdl_pend = 1'b0;
        e.an = 4'hF; e.seg = 8'hFF; e.fs = 1'b0; e.pend = 1'b0;
        sb_q.push_back(e);
      end else begin
        dwell = m % DWELL;
        dig   = (m / DWELL) % DIGITS;
        bnd   = ((m % FRAME) == FRAME - 1);
        phase = dwell / (DWELL / 4);
        for (int i = 0; i < 4; i++) begin
          all_dark = 1'b1;
          for (int j = i + 1; j < 4; j++) all_dark = all_dark && (supp[j] || mdl_ds_bl[j]);
          supp[i] = 1'b0;
        end
        for (int i = 3; i >= 0; i--) begin
          all_dark = 1'b1;
          for (int j = i + 1; j < 4; j++) all_dark = all_dark && (supp[j] || mdl_ds_bl[j]);
          supp[i] = lz_en && (i != 0) && (mdl_ds_dig[i] == 4'h0) && !mdl_ds_dp[i] && all_dark;
        end
        lit = !mdl_ds_bl[dig] && !supp[dig] && (phase <= mdl_br);
        e.an  = lit ? (4'hF ^ (4'h1 << dig)) : 4'hF;
        e.seg = lit ? {~mdl_ds_dp[dig], seg_tab[mdl_ds_dig[dig]][6:0]} : 8'hFF;
        e.fs  = bnd;
        if (bnd && mdl_pend) begin
          mdl_ds_dig = mdl_sh_dig; mdl_ds_dp = mdl_sh_dp; mdl_ds_bl = mdl_sh_bl;
          mdl_pend = 1'b0;
        end
        if (load) begin
          for (int i = 0; i < 4; i++) mdl_sh_dig[i] = digits[4*i +: 4];
          mdl_sh_dp = dp; mdl_sh_bl = blank; mdl_pend = 1'b1;
        end
        if (dwell == 0) mdl_br = int'(brightness);
        e.pend = mdl_pend;
        sb_q.push_back(e);
        m++;
      end
    end
  end

  // Monitor: one expected word per clock, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty: no expected entry at cycle %0d", m);
      end else begin
        e = sb_q.pop_front();
        if ({anodes, segments_out, frame_start, pending} !== e) begin
          bad++;
          $display("FAIL scoreboard cyc=%0d: got an=%h seg=%h fs=%b pend=%b expected an=%h seg=%h fs=%b pend=%b",
                   m, anodes, segments_out, frame_start, pending, e.an, e.seg, e.fs, e.pend);
        end
      end
    end
  end

  task automatic wait_mod(input int t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (((m % FRAME) != t) && (k < 2 * FRAME));
    if ((m % FRAME) != t) begin
      total++;
      bad++;
      $display("FAIL wait_mod: reached %0d expected %0d", m % FRAME, t);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits = d; dp = p; blank = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_lit(input string nm, input int expv);
    int cnt;
    cnt = 0;
    wait_mod(0);
    repeat (FRAME) begin
      @(negedge clk);
      if (anodes != 4'hF) cnt++;
    end
    chk(nm, cnt, expv);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; digits = 16'h0; dp = 4'h0; blank = 4'h0;
    lz_en = 1'b0; load = 1'b0; brightness = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_anodes", anodes, 4'hF);
    chk("rst_segments", segments_out, 8'hFF);
    chk("rst_pending", pending, 1'b0);
    chk("rst_frame_start", frame_start, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_lit_an", anodes, 4'hE);
    chk("first_lit_seg", segments_out, 8'hC0);

    wait_mod(5);
    do_load(16'h1234, 4'h0, 4'h0);
    chk("pending_after_load", pending, 1'b1);
    wait_mod(20);
    chk("frame0_an", anodes, 4'hD);
    chk("frame0_seg", segments_out, 8'hC0);
    wait_mod(0);
    chk("frame_start_pulse", frame_start, 1'b1);
    chk("pending_cleared", pending, 1'b0);
    wait_mod(20);
    chk("frame1_seg", segments_out, 8'hB0);

    brightness = 2'd0;
    count_lit("lit_count_b0", 16);
    brightness = 2'd2;
    count_lit("lit_count_b2", 48);
    brightness = 2'd3;

    lz_en = 1'b1;
    wait_mod(5);
    do_load(16'h00A5, 4'h0, 4'h0);
    wait_mod(0);
    wait_mod(8);
    chk("lz_d0_seg", segments_out, 8'h92);
    wait_mod(20);
    chk("lz_d1_seg", segments_out, 8'h88);
    wait_mod(40);
    chk("lz_d2_dark", {anodes, segments_out}, 12'hFFF);
    wait_mod(56);
    chk("lz_d3_dark", {anodes, segments_out}, 12'hFFF);
    do_load(16'h00A5, 4'h8, 4'h0);
    wait_mod(0);
    wait_mod(40);
    chk("lzdp_d2", {anodes, segments_out}, {4'hB, 8'hC0});
    wait_mod(56);
    chk("lzdp_d3", {anodes, segments_out}, {4'h7, 8'h40});
    lz_en = 1'b0;

    wait_mod(10);
    do_load(16'h1111, 4'h0, 4'h0);
    wait_mod(20);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_mod(63);
    do_load(16'h3333, 4'h0, 4'h0);
    chk("boundary_load_pending", pending, 1'b1);
    wait_mod(20);
    chk("shows_2222", segments_out, 8'hA4);
    wait_mod(0);
    chk("pending_after_3333", pending, 1'b0);
    wait_mod(20);
    chk("shows_3333", segments_out, 8'hB0);

    wait_mod(5);
    do_load(16'h1234, 4'h0, 4'b0101);
    wait_mod(0);
    wait_mod(8);
    chk("blank_d0", {anodes, segments_out}, 12'hFFF);
    wait_mod(24);
    chk("blank_d1_lit", {anodes, segments_out}, {4'hD, 8'hB0});
    wait_mod(40);
    chk("blank_d2", {anodes, segments_out}, 12'hFFF);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      case ($urandom_range(0, 3))
        0, 1: begin
          logic [15:0] d;
          for (int n = 0; n < 4; n++) d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
          do_load(d, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        2:       brightness = 2'($urandom_range(0, 3));
        default: lz_en = 1'($urandom_range(0, 1));
      endcase
    end

    wait_mod(5);
    do_load(16'h9876, 4'h0, 4'h0);
    wait_mod(40);
    reset = 1'b1;
    #1;
    chk("midrst_anodes", anodes, 4'hF);
    chk("midrst_segments", segments_out, 8'hFF);
    chk("midrst_pending", pending, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_digit0", {anodes, segments_out}, {4'hE, 8'hC0});
    repeat (2 * FRAME) @(negedge clk);
    chk("load_discarded", pending, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
